// File: rtl/alu_result_tx_ctrl_pkg.sv
// Shared definitions for the ALU result serializer: FSM encoding, default
// geometry and the derived byte-count / pointer-width constants.
package alu_result_tx_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_DEPTH      = 2;

    // Number of UART bytes needed to carry one ALU result.
    function automatic int bytes_of(input int out_width, input int data_width);
        return out_width / data_width;
    endfunction

    // Width of a counter/pointer addressing n items; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BYTES = bytes_of(DEF_OUT_WIDTH, DEF_DATA_WIDTH);
    localparam int PTR_W = idx_width(DEF_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/alu_result_tx_ctrl_result_fifo.sv
// Small synchronous result FIFO. Storage is a register array with a
// fall-through read port so the head word is available in the pop cycle.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module alu_result_tx_ctrl_result_fifo
    import alu_result_tx_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_OUT_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW    = idx_width(DEPTH);
    localparam int CNT_W = PW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_wr;
    logic             do_rd;

    // Accept/pop qualification: a pop frees the slot a full-FIFO write needs.
    always_comb begin
        do_rd = rd_en & ~empty;
        do_wr = wr_en & (~full | do_rd);
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Status and head-of-queue data, all derived from registers.
    always_comb begin
        full    = (count_reg == CNT_W'(DEPTH));
        empty   = (count_reg == '0);
        rd_data = mem_reg[rd_ptr_reg];
    end

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Serializes buffered ALU results into UART bytes, LSB byte first, using a
// four-phase handshake on TX_BUSY for every byte. Results arriving while the
// FIFO is full (and not being popped) are dropped and latch OVERFLOW.
module alu_result_tx_ctrl
    import alu_result_tx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  BUSY,
    output logic                  OVERFLOW
);

    localparam int N_BYTES = bytes_of(OUT_WIDTH, DATA_WIDTH);
    localparam int IDX_W   = idx_width(N_BYTES);

    tx_state_e             state_reg;
    tx_state_e             state_next;
    logic [IDX_W-1:0]      byte_idx_reg;
    logic [IDX_W-1:0]      byte_idx_next;
    logic [OUT_WIDTH-1:0]  hold_reg;
    logic [DATA_WIDTH-1:0] tx_p_data_reg;
    logic                  overflow_reg;
    logic                  last_byte;

    logic                  fifo_rd_en;
    logic [OUT_WIDTH-1:0]  fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [DATA_WIDTH-1:0] hold_bytes [N_BYTES];

    // Byte lanes of the held result, lane 0 being the least significant.
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_lanes
        assign hold_bytes[gi] = hold_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    alu_result_tx_ctrl_result_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (OUT_VALID),
        .wr_data (ALU_OUT),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state, byte index and pop decisions.
    always_comb begin
        state_next    = state_reg;
        byte_idx_next = byte_idx_reg;
        fifo_rd_en    = 1'b0;
        last_byte     = (byte_idx_reg == IDX_W'(N_BYTES - 1));
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_rd_en    = 1'b1;
                    byte_idx_next = '0;
                    state_next    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!TX_BUSY) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                state_next = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (TX_BUSY) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!TX_BUSY) begin
                    if (last_byte) begin
                        state_next = ST_IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 1'b1;
                        state_next    = ST_SEND;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs, decoded only from registered state.
    always_comb begin
        TX_D_VLD  = (state_reg == ST_SEND);
        BUSY      = (state_reg != ST_IDLE) | ~fifo_empty;
        TX_P_DATA = tx_p_data_reg;
        OVERFLOW  = overflow_reg;
    end

    // Datapath: hold register, byte index, output byte latch and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg      <= '0;
            byte_idx_reg  <= '0;
            tx_p_data_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            byte_idx_reg <= byte_idx_next;
            if (fifo_rd_en) begin
                hold_reg <= fifo_rd_data;
            end
            // Byte is latched on entry to SEND and then held until the next one.
            if (state_next == ST_SEND) begin
                tx_p_data_reg <= hold_bytes[byte_idx_next];
            end
            if (OUT_VALID && fifo_full && !fifo_rd_en) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Directed bench for alu_result_tx_ctrl: a table of single-result transfers
// plus hand-written sequences for overflow, stalled UART, reset mid-transfer
// and a UART that never acknowledges.
module tb_alu_result_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        BUSY;
    logic        OVERFLOW;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // UART model controls
    logic uart_ack   = 1'b1;
    logic force_busy = 1'b0;
    int   busy_cnt   = 0;

    logic [7:0] byte_q [$];
    int         cyc_q  [$];

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs [5];

    alu_result_tx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ALU_OUT   (ALU_OUT),
        .OUT_VALID (OUT_VALID),
        .TX_BUSY   (TX_BUSY),
        .TX_P_DATA (TX_P_DATA),
        .TX_D_VLD  (TX_D_VLD),
        .BUSY      (BUSY),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART: busy rises the cycle after a byte strobe and stays up 10 cycles.
    always @(posedge clk) begin
        if (uart_ack && TX_D_VLD) begin
            busy_cnt <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign TX_BUSY = force_busy | (busy_cnt != 0);

    // Byte monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (TX_D_VLD === 1'b1) begin
            byte_q.push_back(TX_P_DATA);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        check({tag, "_rst_data"}, 32'(TX_P_DATA), 32'h0);
        check({tag, "_rst_vld"},  32'(TX_D_VLD),  32'h0);
        check({tag, "_rst_busy"}, 32'(BUSY),      32'h0);
        check({tag, "_rst_ovf"},  32'(OVERFLOW),  32'h0);
    endtask

    task automatic send_word(input logic [15:0] w);
        ALU_OUT   = w;
        OUT_VALID = 1'b1;
        tick;
        OUT_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget, output int idle_cyc);
        int i;
        i = 0;
        while (BUSY !== 1'b0 && i < budget) begin
            tick;
            i++;
        end
        check({tag, "_idle_reached"}, 32'(BUSY), 32'h0);
        idle_cyc = cyc;
    endtask

    initial begin
        int start;
        int idle_c;
        int f;
        int i;
        logic [7:0] exp2 [6];

        rst       = 1'b1;
        ALU_OUT   = '0;
        OUT_VALID = 1'b0;

        vecs[0] = '{16'h1234, 8'h34, 8'h12};
        vecs[1] = '{16'h0000, 8'h00, 8'h00};
        vecs[2] = '{16'hFF00, 8'h00, 8'hFF};
        vecs[3] = '{16'h00FF, 8'hFF, 8'h00};
        vecs[4] = '{16'hA55A, 8'h5A, 8'hA5};

        reset_and_check("init");

        // Single-result transfers
        foreach (vecs[k]) begin
            byte_q.delete();
            cyc_q.delete();
            start = cyc;
            send_word(vecs[k].word);
            wait_idle("tbl", 100, idle_c);
            check("tbl_pulses", 32'(byte_q.size()), 32'd2);
            if (byte_q.size() >= 2) begin
                check("tbl_byte0",   32'(byte_q[0]), 32'(vecs[k].b0));
                check("tbl_byte1",   32'(byte_q[1]), 32'(vecs[k].b1));
                check("tbl_latency", 32'(cyc_q[0] - start), 32'd3);
                check("tbl_gap",     32'(cyc_q[1] - cyc_q[0]), 32'd12);
                check("tbl_idle",    32'(idle_c - cyc_q[1]), 32'd12);
                $display("txn tbl %0d: word=0x%04h bytes=0x%02h,0x%02h first@+%0d",
                         k, vecs[k].word, byte_q[0], byte_q[1], cyc_q[0] - start);
            end
            check("tbl_hold_data", 32'(TX_P_DATA), 32'(vecs[k].b1));
            check("tbl_ovf",       32'(OVERFLOW),  32'h0);
        end

        // Four back-to-back results into a 2-deep FIFO: the fourth is dropped
        reset_and_check("ovf");
        byte_q.delete();
        cyc_q.delete();
        for (int w = 1; w <= 4; w++) begin
            ALU_OUT   = 16'(w);
            OUT_VALID = 1'b1;
            if (w == 4) begin
                check("ovf_before_drop", 32'(OVERFLOW), 32'h0);
            end
            tick;
        end
        OUT_VALID = 1'b0;
        check("ovf_set", 32'(OVERFLOW), 32'h1);
        wait_idle("ovf", 300, idle_c);
        exp2 = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        check("ovf_pulses", 32'(byte_q.size()), 32'd6);
        if (byte_q.size() >= 6) begin
            for (int j = 0; j < 6; j++) begin
                check("ovf_byte", 32'(byte_q[j]), 32'(exp2[j]));
            end
        end
        check("ovf_held", 32'(OVERFLOW), 32'h1);
        $display("txn ovf: %0d bytes sent, OVERFLOW=%0b", byte_q.size(), OVERFLOW);

        // UART busy before the result arrives: FSM must wait in ARM
        reset_and_check("stall");
        byte_q.delete();
        cyc_q.delete();
        force_busy = 1'b1;
        tick;
        tick;
        send_word(16'hABCD);
        repeat (6) tick;
        check("stall_no_pulse", 32'(byte_q.size()), 32'd0);
        check("stall_vld",      32'(TX_D_VLD),      32'h0);
        check("stall_busy",     32'(BUSY),          32'h1);
        force_busy = 1'b0;
        f = cyc;
        wait_idle("stall", 100, idle_c);
        check("stall_pulses", 32'(byte_q.size()), 32'd2);
        if (byte_q.size() >= 2) begin
            check("stall_release", 32'(cyc_q[0] - f), 32'd1);
            check("stall_byte0",   32'(byte_q[0]), 32'hCD);
            check("stall_byte1",   32'(byte_q[1]), 32'hAB);
        end
        $display("txn stall: word=0xABCD, %0d bytes sent", byte_q.size());

        // Reset while in WAIT_DONE after the first byte
        reset_and_check("midrst");
        byte_q.delete();
        cyc_q.delete();
        send_word(16'h1234);
        i = 0;
        while (byte_q.size() < 1 && i < 50) begin
            tick;
            i++;
        end
        check("midrst_first_pulse", 32'(byte_q.size()), 32'd1);
        if (byte_q.size() >= 1) begin
            check("midrst_byte0", 32'(byte_q[0]), 32'h34);
        end
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_data", 32'(TX_P_DATA), 32'h0);
        check("midrst_vld",  32'(TX_D_VLD),  32'h0);
        check("midrst_busy", 32'(BUSY),      32'h0);
        check("midrst_ovf",  32'(OVERFLOW),  32'h0);
        repeat (30) tick;
        check("midrst_no_more", 32'(byte_q.size()), 32'd1);
        check("midrst_idle",    32'(BUSY),          32'h0);
        $display("txn midrst: word=0x1234, %0d bytes sent before abandon", byte_q.size());

        // UART that never acknowledges: FSM parks in WAIT_ACK
        reset_and_check("noack");
        byte_q.delete();
        cyc_q.delete();
        uart_ack = 1'b0;
        send_word(16'h1234);
        repeat (40) tick;
        check("noack_pulses", 32'(byte_q.size()), 32'd1);
        if (byte_q.size() >= 1) begin
            check("noack_byte0", 32'(byte_q[0]), 32'h34);
        end
        check("noack_busy", 32'(BUSY),     32'h1);
        check("noack_vld",  32'(TX_D_VLD), 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("noack_rst_busy", 32'(BUSY), 32'h0);
        uart_ack = 1'b1;
        $display("txn noack: word=0x1234, %0d bytes sent, parked until reset", byte_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
